// File: rtl/pipelined_write_arbiter.sv
// pipelined_write_arbiter
//   Shares one 10-bit pipelined-write bus between NUM_REQ requesters. Each
//   requester offers a whole transaction (beat count, write type, up to
//   MAX_WR_CYCLES data bytes). A round-robin arbiter picks a winner in IDLE,
//   latches its transaction, then emits one command word followed by N data
//   words. Write-done pulses go back to the winner according to its write type.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_vld/rdy     per-requester offer / one-cycle accept pulse (one-hot)
//   req_num_cycles  2 bits per requester, 0 encodes MAX_WR_CYCLES
//   req_write_type  3 bits per requester: 0 STD, 1 MULTI_WDONE, 2 SINGLE_WDONE
//   req_dat         MAX_WR_CYCLES*WR_WIDTH bits per requester, beat 0 in the LSBs
//   req_wdone       per-requester write-done pulses
//   out_vld/rdy     bus handshake, out_word = command or data word
//   busy            transaction in progress (state != IDLE)
//   grant_id        requester owning the current / last transaction
//
// The 10-bit word layout assumes WR_WIDTH == 8 and MAX_WR_CYCLES <= 4.
module pipelined_write_arbiter #(
    parameter int  NUM_REQ       = 4,
    parameter int  MAX_WR_CYCLES = 4,
    parameter int  WR_WIDTH      = 8,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_vld,
    output logic [NUM_REQ-1:0]                    req_rdy,
    input  logic [2*NUM_REQ-1:0]                  req_num_cycles,
    input  logic [3*NUM_REQ-1:0]                  req_write_type,
    input  logic [MAX_WR_CYCLES*WR_WIDTH*NUM_REQ-1:0] req_dat,
    output logic [NUM_REQ-1:0]                    req_wdone,
    output logic                                  out_vld,
    input  logic                                  out_rdy,
    output logic [9:0]                            out_word,
    output logic                                  busy,
    output logic [ID_W-1:0]                       grant_id
);

    localparam int BEAT_W = (MAX_WR_CYCLES > 1) ? $clog2(MAX_WR_CYCLES) : 1;

    localparam logic [1:0] CT_VALID = 2'd1;
    localparam logic [1:0] CT_DONE  = 2'd2;
    localparam logic [2:0] WT_MULTI  = 3'd1;
    localparam logic [2:0] WT_SINGLE = 3'd2;

    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} state_t;

    // Per-requester views of the flat input buses
    logic [NUM_REQ-1:0][1:0]                              nc_arr;
    logic [NUM_REQ-1:0][2:0]                              wt_arr;
    logic [NUM_REQ-1:0][MAX_WR_CYCLES-1:0][WR_WIDTH-1:0]  dat_arr;

    assign nc_arr  = req_num_cycles;
    assign wt_arr  = req_write_type;
    assign dat_arr = req_dat;

    state_t                               state, state_nx;
    logic [ID_W-1:0]                      ptr, ptr_nx, win;
    logic                                 found, grant;
    logic [1:0]                           lat_nc;
    logic [2:0]                           lat_wt;
    logic [MAX_WR_CYCLES-1:0][WR_WIDTH-1:0] lat_dat;
    logic [BEAT_W-1:0]                    beat, beat_nx, nb, last_idx;
    logic                                 is_last;
    logic                                 out_vld_nx;
    logic [9:0]                           out_word_nx, data_word;
    logic [NUM_REQ-1:0]                   wdone_nx;

    // Round-robin search: first requester at or above ptr, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_vld[ID_W'(idx)]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    assign ptr_nx = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);

    // Accept is combinational so the request is taken in the same IDLE cycle.
    always_comb begin
        req_rdy = '0;
        if (state == IDLE && found && rst_n) req_rdy[win] = 1'b1;
    end

    // Beat bookkeeping: nb is the beat to present after the current handshake.
    assign last_idx  = (lat_nc == 2'd0) ? BEAT_W'(MAX_WR_CYCLES - 1) : BEAT_W'(lat_nc - 2'd1);
    assign is_last   = (beat == last_idx);
    assign nb        = (state == CMD) ? '0 : beat + BEAT_W'(1);
    assign data_word = {(nb == last_idx) ? CT_DONE : CT_VALID, lat_dat[nb]};
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx    = state;
        out_vld_nx  = out_vld;
        out_word_nx = out_word;
        beat_nx     = beat;
        wdone_nx    = '0;
        grant       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant       = 1'b1;
                    state_nx    = CMD;
                    out_vld_nx  = 1'b1;
                    out_word_nx = {4'b0000, 1'b1, nc_arr[win], wt_arr[win]};
                end
            end
            CMD: begin
                if (out_rdy) begin
                    state_nx    = DATA;
                    beat_nx     = '0;
                    out_word_nx = data_word;
                end
            end
            DATA: begin
                if (out_rdy) begin
                    if (lat_wt == WT_MULTI || (lat_wt == WT_SINGLE && is_last))
                        wdone_nx[grant_id] = 1'b1;
                    if (is_last) begin
                        state_nx    = IDLE;
                        out_vld_nx  = 1'b0;
                        out_word_nx = '0;
                    end else begin
                        beat_nx     = nb;
                        out_word_nx = data_word;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            lat_nc    <= '0;
            lat_wt    <= '0;
            lat_dat   <= '0;
            beat      <= '0;
            out_vld   <= 1'b0;
            out_word  <= '0;
            req_wdone <= '0;
        end else begin
            state     <= state_nx;
            beat      <= beat_nx;
            out_vld   <= out_vld_nx;
            out_word  <= out_word_nx;
            req_wdone <= wdone_nx;
            if (grant) begin
                lat_nc   <= nc_arr[win];
                lat_wt   <= wt_arr[win];
                lat_dat  <= dat_arr[win];
                grant_id <= win;
                ptr      <= ptr_nx;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_write_arbiter.sv
// Scoreboard bench for pipelined_write_arbiter (NUM_REQ=4, 4 beats, 8-bit data).
// A monitor at the falling edge predicts the grant from a round-robin pointer,
// queues the expected bus words of each accepted transaction, and checks
// req_rdy, busy, out_vld, out_word, grant_id and req_wdone every cycle.
module tb_pipelined_write_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_vld = '0;
    logic [3:0]   req_rdy;
    logic [7:0]   req_num_cycles = '0;
    logic [11:0]  req_write_type = '0;
    logic [127:0] req_dat = '0;
    logic [3:0]   req_wdone;
    logic         out_vld;
    logic         out_rdy = 1'b1;
    logic [9:0]   out_word;
    logic         busy;
    logic [1:0]   grant_id;

    pipelined_write_arbiter #(.NUM_REQ(4), .MAX_WR_CYCLES(4), .WR_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_num_cycles(req_num_cycles), .req_write_type(req_write_type),
        .req_dat(req_dat), .req_wdone(req_wdone),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_word(out_word),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [9:0] word;
        bit         is_data;
        bit         last;
        int         owner;
        int         wt;
    } exp_t;

    exp_t       exp_q[$];
    int         mptr = 0;
    bit         exp_busy = 0;
    logic [3:0] exp_wdone = '0;
    logic [3:0] rdy_seen = '0;
    int         wd_cnt[4];
    int         gcnt[4];
    int         grant_log[$];

    always @(negedge clk) begin
        logic [3:0] exp_rdy, nxt_wdone;
        bit         nxt_busy;
        int         win, n;
        logic [1:0] nc;
        logic [2:0] wt;
        logic [31:0] d;
        exp_t       e;
        if (!rst_n) begin
            exp_q.delete();
            mptr      = 0;
            exp_busy  = 0;
            exp_wdone = '0;
            rdy_seen  = '0;
        end else begin
            win = -1;
            exp_rdy = '0;
            if (!exp_busy)
                for (int k = 0; k < 4; k++)
                    if (win < 0 && req_vld[(mptr + k) % 4]) win = (mptr + k) % 4;
            if (win >= 0) exp_rdy[win] = 1'b1;

            chk("busy", 32'(busy), 32'(exp_busy));
            chk("out_vld", 32'(out_vld), 32'(exp_busy));
            chk("req_wdone", 32'(req_wdone), 32'(exp_wdone));
            chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
            for (int k = 0; k < 4; k++) if (req_wdone[k]) wd_cnt[k]++;

            nxt_wdone = '0;
            nxt_busy  = exp_busy;
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: actual=%0h expected=none t=%0t", out_word, $time);
                end else begin
                    e = exp_q[0];
                    chk("out_word", 32'(out_word), 32'(e.word));
                    chk("grant_id", 32'(grant_id), 32'(e.owner));
                    if (out_rdy) begin
                        void'(exp_q.pop_front());
                        if (e.is_data && (e.wt == 1 || (e.wt == 2 && e.last))) nxt_wdone[e.owner] = 1'b1;
                        if (e.last) nxt_busy = 0;
                    end
                end
            end

            if (win >= 0) begin
                nc = req_num_cycles[2*win +: 2];
                wt = req_write_type[3*win +: 3];
                d  = req_dat[32*win +: 32];
                n  = (nc == 2'd0) ? 4 : int'(nc);
                e.word = {4'b0000, 1'b1, nc, wt};
                e.is_data = 0; e.last = 0; e.owner = win; e.wt = int'(wt);
                exp_q.push_back(e);
                for (int k = 0; k < n; k++) begin
                    e.word    = {(k == n - 1) ? 2'b10 : 2'b01, d[8*k +: 8]};
                    e.is_data = 1;
                    e.last    = (k == n - 1);
                    exp_q.push_back(e);
                end
                mptr = (win + 1) % 4;
                nxt_busy = 1;
                gcnt[win]++;
                grant_log.push_back(win);
            end
            rdy_seen  = req_rdy;
            exp_busy  = nxt_busy;
            exp_wdone = nxt_wdone;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input logic [1:0] nc, input logic [2:0] wt, input logic [31:0] d);
        req_num_cycles[2*i +: 2] = nc;
        req_write_type[3*i +: 3] = wt;
        req_dat[32*i +: 32]      = d;
        req_vld[i]               = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        req_vld = '0;
        #1;
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wdone", 32'(req_wdone), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_out_word", 32'(out_word), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        @(posedge clk);
        #1 req_vld = '0;
        out_rdy = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !exp_busy) done = 1;
        end
        chk("drain_done", 32'(done), 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic drive_random();
        for (int i = 0; i < 4; i++) begin
            if (rdy_seen[i]) req_vld[i] = 1'b0;
            else if (req_vld[i]) begin
                if ($urandom_range(0, 31) == 0) req_vld[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0)
                set_req(i, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom);
        end
        out_rdy = ($urandom_range(0, 3) != 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int ord[5];
        int mn, mx, snap;
        ord = '{0, 1, 2, 3, 0};

        do_reset();

        // Single-beat STD on requester 0: exact latency and word encodings
        @(posedge clk);
        #1 set_req(0, 2'd1, 3'd0, 32'h123456A5);
        @(negedge clk) chk("p1_rdy", 32'(req_rdy), 32'h1);
        @(posedge clk);
        #1 req_vld[0] = 1'b0;
        @(negedge clk) chk("p1_cmd", 32'(out_word), 32'(10'b0000_1_01_000));
        @(negedge clk) chk("p1_data", 32'(out_word), 32'(10'b10_10100101));
        @(negedge clk) chk("p1_busy_low", 32'(busy), 0);

        // Max beats MULTI on requester 1 with stalls in CMD and at beat 2
        wd_cnt = '{0, 0, 0, 0};
        @(posedge clk);
        #1 set_req(1, 2'd0, 3'd1, 32'h44332211);
        out_rdy = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) req_vld[1] = 1'b0;
            out_rdy = !(c inside {1, 2, 3, 7, 8});
        end
        chk("p2_wdone_cnt", 32'(wd_cnt[1]), 4);
        drain();

        // Round-robin fairness with all requesters busy
        do_reset();
        grant_log.delete();
        gcnt = '{0, 0, 0, 0};
        for (int i = 0; i < 4; i++) set_req(i, 2'd1, 3'd0, $urandom);
        req_vld = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) req_vld[i] = !rdy_seen[i];
        end
        drain();
        chk("rr_log_size", 32'(grant_log.size() >= 5), 1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("rr_order", 32'(grant_log[k]), 32'(ord[k]));
        mn = gcnt[0]; mx = gcnt[0];
        for (int i = 1; i < 4; i++) begin
            if (gcnt[i] < mn) mn = gcnt[i];
            if (gcnt[i] > mx) mx = gcnt[i];
        end
        chk("rr_fair_spread", 32'(mx - mn), (mx - mn <= 1) ? 32'(mx - mn) : 1);

        // SINGLE_WDONE on requester 2 while requester 3 waits
        do_reset();
        wd_cnt = '{0, 0, 0, 0};
        @(posedge clk);
        #1 set_req(2, 2'd2, 3'd2, 32'hCAFE5A3C);
        set_req(3, 2'd1, 3'd0, 32'h000000EE);
        out_rdy = 1'b1;
        @(negedge clk) chk("p4_rdy2", 32'(req_rdy), 32'h4);
        @(posedge clk);
        #1 req_vld[2] = 1'b0;
        repeat (4) @(negedge clk);
        chk("p4_wdone2", 32'(req_wdone), 32'h4);
        chk("p4_rdy3_same_cycle", 32'(req_rdy), 32'h8);
        drain();
        chk("p4_wdone_cnt", 32'(wd_cnt[2]), 1);

        // Reset during data beat 1 of a MULTI transaction
        wd_cnt = '{0, 0, 0, 0};
        @(posedge clk);
        #1 set_req(2, 2'd0, 3'd1, 32'h0BADF00D);
        @(negedge clk) chk("p5_rdy2", 32'(req_rdy), 32'h4);
        @(posedge clk);
        #1 req_vld[2] = 1'b0;
        @(posedge clk);
        do_reset();
        snap = wd_cnt[2];
        @(posedge clk);
        #1 set_req(0, 2'd1, 3'd0, 32'h11);
        set_req(3, 2'd1, 3'd0, 32'h33);
        @(negedge clk) chk("p5_first_grant", 32'(req_rdy), 32'h1);
        drain();
        chk("p5_no_wdone", 32'(wd_cnt[2]), 32'(snap));
        chk("p5_no_wdone_abs", 32'(wd_cnt[2]), 0);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1 drive_random();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
